// File: rtl/bcd_score_if.sv
// Request/status bundle between the game scoring logic and the BCD score
// accumulator. The master issues increments and the slave owns the score state.
interface bcd_score_if #(
  parameter int DIGITS = 4
);
  logic                  clear;
  logic                  add_valid;
  logic                  add_ready;
  logic [3:0]            add_bcd;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   score;
  logic [4*DIGITS-1:0]   high_score;

  modport master (
    output clear, add_valid, add_bcd,
    input  add_ready, busy, done, overflow, score, high_score
  );

  modport slave (
    input  clear, add_valid, add_bcd,
    output add_ready, busy, done, overflow, score, high_score
  );
endinterface

// File: rtl/bcd_score_counter.sv
// Packed-BCD score accumulator. It adds one BCD digit per clock, least
// significant digit first, and publishes the score only when the whole sum commits.
module bcd_score_counter #(
  parameter int DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  bcd_score_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);

  localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};
  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

  state_e          state_q;
  logic [W-1:0]    work_q;
  logic [W-1:0]    score_q;
  logic [W-1:0]    high_q;
  logic [IW-1:0]   idx_q;
  logic [3:0]      inc_q;
  logic            carry_q;
  logic            ovf_q;
  logic            done_q;

  logic [W-1:0]    work_d;
  logic [3:0]      digit_cur;
  logic [3:0]      addend;
  logic [3:0]      digit_d;
  logic [4:0]      sum;
  logic            carry_d;
  logic            accept;

  assign bus.add_ready  = (state_q == IDLE) && !bus.clear;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.overflow   = ovf_q;
  assign bus.score      = score_q;
  assign bus.high_score = high_q;

  assign accept = bus.add_valid && bus.add_ready;

  // One BCD digit add per cycle; the increment enters only at digit 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    work_d    = work_q;
    digit_cur = work_q[{idx_q, 2'b00} +: 4];
    addend    = (idx_q == '0) ? inc_q : 4'd0;
    sum       = {1'b0, digit_cur} + {1'b0, addend} + {4'b0000, carry_q};
    if (sum > 5'd9) begin
      digit_d = 4'(sum - 5'd10);
      carry_d = 1'b1;
    end else begin
      digit_d = sum[3:0];
      carry_d = 1'b0;
    end
    work_d[{idx_q, 2'b00} +: 4] = digit_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      score_q <= '0;
      high_q  <= '0;
      idx_q   <= '0;
      inc_q   <= 4'd0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.clear) begin
      // A new game aborts any sum in flight without touching the high score.
      state_q <= IDLE;
      score_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            inc_q   <= (bus.add_bcd > 4'd9) ? 4'd9 : bus.add_bcd;
            work_q  <= score_q;
            carry_q <= 1'b0;
            idx_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          work_q  <= work_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            if (carry_d) begin
              score_q <= ALL_NINES;
              ovf_q   <= 1'b1;
            end else begin
              score_q <= work_d;
            end
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Packed BCD orders the same as plain unsigned binary.
          if (score_q > high_q) high_q <= score_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_score_counter.sv
// Self-checking bench for bcd_score_counter: a decimal-arithmetic reference
// model checked every cycle, plus directed scenarios pinned with literal values.
module tb_bcd_score_counter;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_score_if #(.DIGITS(DIGITS)) bus ();

  bcd_score_counter #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain decimal score plus a count of cycles into the operation.
  int  m_score;
  int  m_high;
  int  m_phase;
  int  m_inc;
  bit  m_ovf;
  bit  model_live = 1'b0;
  int  done_cnt   = 0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_score    = 0;
      m_high     = 0;
      m_ovf      = 1'b0;
      m_phase    = 0;
      model_live = 1'b1;
    end else if (!model_live) begin
      m_phase = 0;
    end else if (bus.clear) begin
      m_score = 0;
      m_ovf   = 1'b0;
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (bus.add_valid) begin
        m_inc   = (bus.add_bcd > 4'd9) ? 9 : int'(bus.add_bcd);
        m_phase = 1;
      end
    end else if (m_phase <= DIGITS) begin
      if (m_phase == DIGITS) begin
        if (m_score + m_inc > MAXV) begin
          m_score = MAXV;
          m_ovf   = 1'b1;
        end else begin
          m_score = m_score + m_inc;
        end
      end
      m_phase++;
    end else begin
      if (m_score > m_high) m_high = m_score;
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("score",      bus.score,      to_bcd(m_score));
      check("high_score", bus.high_score, to_bcd(m_high));
      check("overflow",   bus.overflow,   m_ovf);
      check("busy",       bus.busy,       m_phase != 0);
      check("done",       bus.done,       m_phase == DIGITS + 1);
      check("add_ready",  bus.add_ready,  (m_phase == 0) && !bus.clear);
      if (bus.done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Issues one increment, holds add_valid until accepted, then waits for IDLE.
  task automatic add(input logic [3:0] v);
    bit ok;
    ok = 1'b0;
    bus.add_valid = 1'b1;
    bus.add_bcd   = v;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.add_ready) ok = 1'b1;
      tick();
    end
    bus.add_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL accept_timeout: got no add_ready expected accept within 50 cycles");
    end
    repeat (DIGITS + 1) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int acc;

    rst = 1'b1;
    bus.clear     = 1'b0;
    bus.add_valid = 1'b0;
    bus.add_bcd   = 4'd0;

    // Reset state.
    do_reset(2);
    @(negedge clk);
    check("rst_score", bus.score, 16'h0000);
    check("rst_high",  bus.high_score, 16'h0000);
    check("rst_ovf",   bus.overflow, 1'b0);
    check("rst_ready", bus.add_ready, 1'b1);
    check("rst_busy",  bus.busy, 1'b0);
    check("rst_done",  bus.done, 1'b0);
    tick();

    // Basic adds.
    d0 = done_cnt;
    add(4'd7);
    check("basic_7", bus.score, 16'h0007);
    add(4'd5);
    check("basic_12",      bus.score, 16'h0012);
    check("basic_high",    bus.high_score, 16'h0012);
    check("basic_dones",   done_cnt - d0, 2);
    check("model_pin_12",  m_score, 12);

    // Clear aborting the second ADD cycle.
    do_reset(1);
    add(4'd4);
    check("pre_abort_high", bus.high_score, 16'h0004);
    d0 = done_cnt;
    bus.add_valid = 1'b1;
    bus.add_bcd   = 4'd5;
    @(negedge clk);
    check("abort_ready", bus.add_ready, 1'b1);
    tick();
    bus.add_valid = 1'b0;
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    repeat (6) tick();
    check("abort_score", bus.score, 16'h0000);
    check("abort_high",  bus.high_score, 16'h0004);
    check("abort_dones", done_cnt - d0, 0);

    // Clear and add_valid together: no accept.
    bus.clear     = 1'b1;
    bus.add_valid = 1'b1;
    bus.add_bcd   = 4'd2;
    @(negedge clk);
    check("clr_req_ready", bus.add_ready, 1'b0);
    tick();
    bus.clear     = 1'b0;
    bus.add_valid = 1'b0;
    @(negedge clk);
    check("clr_req_busy", bus.busy, 1'b0);
    tick();
    do_reset(1);
    check("rst_high_zero", bus.high_score, 16'h0000);

    // Carry ripple 0999 + 1.
    for (int i = 0; i < 111; i++) add(4'd9);
    check("ripple_pre", bus.score, 16'h0999);
    bus.add_valid = 1'b1;
    bus.add_bcd   = 4'd1;
    @(negedge clk);
    check("ripple_ready0", bus.add_ready, 1'b1);
    tick();
    bus.add_valid = 1'b0;
    for (int i = 0; i < DIGITS + 1; i++) begin
      @(negedge clk);
      check("ripple_ready_low", bus.add_ready, 1'b0);
      check("ripple_score", bus.score, (i < DIGITS) ? 16'h0999 : 16'h1000);
    end
    @(negedge clk);
    check("ripple_ready_back", bus.add_ready, 1'b1);
    check("ripple_high",       bus.high_score, 16'h1000);
    tick();

    // Saturation.
    acc = 1000;
    while (acc + 9 <= 9995) begin
      add(4'd9);
      acc += 9;
    end
    if (acc < 9995) add(4'(9995 - acc));
    check("sat_pre",     bus.score, 16'h9995);
    check("sat_pre_ovf", bus.overflow, 1'b0);
    add(4'd7);
    check("sat_score", bus.score, 16'h9999);
    check("sat_ovf",   bus.overflow, 1'b1);
    check("model_pin_sat", m_score, 9999);
    d0 = done_cnt;
    add(4'd3);
    check("sat_hold",  bus.score, 16'h9999);
    check("sat_ovf2",  bus.overflow, 1'b1);
    check("sat_done",  done_cnt - d0, 1);

    // Clamp of non-BCD increment.
    do_reset(1);
    add(4'd2);
    add(4'hC);
    check("clamp", bus.score, 16'h0011);

    // add_valid pulse while busy is ignored.
    d0 = done_cnt;
    bus.add_valid = 1'b1;
    bus.add_bcd   = 4'd3;
    @(negedge clk);
    tick();
    bus.add_valid = 1'b0;
    tick();
    bus.add_valid = 1'b1;
    bus.add_bcd   = 4'd8;
    tick();
    bus.add_valid = 1'b0;
    repeat (5) tick();
    check("bp_score", bus.score, 16'h0014);
    check("bp_dones", done_cnt - d0, 1);
    check("bp_busy",  bus.busy, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(199) == 0);
      bus.clear     = ($urandom_range(39) == 0);
      bus.add_valid = ($urandom_range(2) != 0);
      bus.add_bcd   = 4'($urandom_range(15));
      tick();
    end
    rst           = 1'b0;
    bus.clear     = 1'b0;
    bus.add_valid = 1'b0;
    repeat (DIGITS + 3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
